// File: rtl/mem_ctrl_if.sv
// Bus bundle between the fetch/load-store requesters, mem_ctrl and a byte RAM.
// Request side: if_*, mem_*; RAM side: ram_a, ram_dout, ram_wr, ram_din.
interface mem_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr,
    input  mem_len, mem_wdata,
    input  ram_din,
    output if_done, if_data,
    output mem_done, mem_rdata,
    output ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr,
    output mem_len, mem_wdata,
    output ram_din,
    input  if_done, if_data,
    input  mem_done, mem_rdata,
    input  ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto one synchronous byte RAM.
// Ports: clk, rst (async, active high), bus (mem_ctrl_if.slave).
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input logic     clk,
  input logic     rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t            state_q;
  logic              last_mem_q;
  logic              sel_mem_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [2:0]        len_q;
  logic [2:0]        t_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic [7:0]        dout_q;
  logic              wr_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic [2:0]        step;
  logic [2:0]        mem_n;
  logic              grant_if;
  logic              grant_mem;
  logic [31:0]       rbuf_d;
  logic [7:0]        wbyte;
  logic [ADDR_W-1:0] next_a;

  // step = edges since acceptance, counting
  // the edge currently being evaluated
  always_comb begin
    step   = t_q + 3'd1;
    next_a = base_q
           + {{(ADDR_W-3){1'b0}}, step};
    mem_n  = 3'd4;
    if (bus.mem_len == 2'b00) mem_n = 3'd1;
    if (bus.mem_len == 2'b01) mem_n = 3'd2;
    // on contention, the side not served
    // last time wins
    grant_mem = bus.mem_req
              & (~bus.if_req | ~last_mem_q);
    grant_if  = bus.if_req & ~grant_mem;
  end

  // RAM data for byte k arrives at step k+2
  always_comb begin
    rbuf_d = rbuf_q;
    case (step)
      3'd2:    rbuf_d[7:0]   = bus.ram_din;
      3'd3:    rbuf_d[15:8]  = bus.ram_din;
      3'd4:    rbuf_d[23:16] = bus.ram_din;
      3'd5:    rbuf_d[31:24] = bus.ram_din;
      default: ;
    endcase
  end

  always_comb begin
    wbyte = 8'h00;
    case (step)
      3'd1:    wbyte = wdata_q[15:8];
      3'd2:    wbyte = wdata_q[23:16];
      3'd3:    wbyte = wdata_q[31:24];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      sel_mem_q   <= 1'b0;
      base_q      <= '0;
      ram_a_q     <= '0;
      len_q       <= 3'd0;
      t_q         <= 3'd0;
      wdata_q     <= 32'h0;
      rbuf_q      <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      dout_q      <= 8'h00;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_if | grant_mem) begin
            last_mem_q <= grant_mem;
            sel_mem_q  <= grant_mem;
            t_q        <= 3'd0;
            rbuf_q     <= 32'h0;
            wdata_q    <= bus.mem_wdata;
            if (grant_mem) begin
              base_q  <= bus.mem_addr;
              ram_a_q <= bus.mem_addr;
              len_q   <= mem_n;
            end else begin
              base_q  <= bus.if_addr;
              ram_a_q <= bus.if_addr;
              len_q   <= 3'd4;
            end
            if (grant_mem && bus.mem_we) begin
              state_q <= WRITE;
              wr_q    <= 1'b1;
              dout_q  <= bus.mem_wdata[7:0];
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          t_q    <= step;
          rbuf_q <= rbuf_d;
          if (step < len_q) ram_a_q <= next_a;
          if (step == len_q + 3'd1) begin
            state_q <= DONE;
            if (sel_mem_q) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= rbuf_d;
            end else begin
              if_done_q <= 1'b1;
              if_data_q <= rbuf_d;
            end
          end
        end
        WRITE: begin
          t_q <= step;
          if (step < len_q) begin
            ram_a_q <= next_a;
            dout_q  <= wbyte;
          end else begin
            wr_q       <= 1'b0;
            dout_q     <= 8'h00;
            mem_done_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = dout_q;
  assign bus.ram_wr    = wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Random fetch/load/store traffic against mem_ctrl with a byte-RAM model,
// checked against a reference memory image and latency rules.
module tb_mem_ctrl;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(AW)) bus ();
  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] ram     [MSZ];
  logic [7:0] ref_mem [MSZ];

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a];
  end

  int passed = 0;
  int total  = 0;

  bit          last_mem_ref;
  logic [31:0] last_if;
  logic [31:0] last_mem;
  bit          have_mem;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic int nbytes(input logic [1:0] l);
    if (l == 2'b00) return 1;
    if (l == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_read(input int a,
                                           input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < n; k++)
      r[8*k +: 8] = ref_mem[(a + k) & (MSZ - 1)];
    return r;
  endfunction

  always @(negedge clk)
    if (!rst && (bus.if_done || bus.mem_done))
      check("excl_done",
            64'(bus.if_done & bus.mem_done), 64'd0);

  // Drives one request from a negedge in IDLE; returns the cycle
  // (1 = first cycle after acceptance) in which done was seen.
  task automatic access(input bit is_if, input bit we,
                        input logic [AW-1:0] a,
                        input logic [1:0] len,
                        input logic [31:0] wd,
                        output logic [31:0] data,
                        output int lat);
    int n;
    bit err;
    bit seen;
    logic [AW-1:0] ea;
    n = is_if ? 4 : nbytes(len);
    err = 1'b0;
    seen = 1'b0;
    lat = -1;
    data = 32'h0;
    if (is_if) begin
      bus.if_req = 1'b1;
      bus.if_addr = a;
    end else begin
      bus.mem_req = 1'b1;
      bus.mem_we = we;
      bus.mem_addr = a;
      bus.mem_len = len;
      bus.mem_wdata = wd;
    end
    @(posedge clk);
    #1;
    if (is_if) bus.if_addr = AW'($urandom);
    else begin
      bus.mem_addr = AW'($urandom);
      bus.mem_wdata = $urandom;
      bus.mem_len = 2'($urandom);
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ea = a + AW'(c - 1);
      if (c <= n) begin
        if (!is_if && we) begin
          if (bus.ram_wr !== 1'b1 || bus.ram_a !== ea ||
              bus.ram_dout !== wd[8*(c-1) +: 8]) err = 1'b1;
        end else if (bus.ram_a !== ea) err = 1'b1;
      end
      if ((is_if || !we) && bus.ram_wr !== 1'b0) err = 1'b1;
      if (is_if ? bus.mem_done : bus.if_done) err = 1'b1;
      if (is_if ? bus.if_done : bus.mem_done) begin
        lat = c;
        data = is_if ? bus.if_data : bus.mem_rdata;
        seen = 1'b1;
        break;
      end
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("bus_seq", 64'(err), 64'd0);
    if (seen) begin
      @(negedge clk);
      check("done_pulse",
            64'(is_if ? bus.if_done : bus.mem_done), 64'd0);
    end
  endtask

  task automatic do_op(input bit is_if, input bit we,
                       input logic [AW-1:0] a,
                       input logic [1:0] len,
                       input logic [31:0] wd);
    int n;
    int lat;
    int el;
    logic [31:0] d;
    logic [31:0] e;
    n = is_if ? 4 : nbytes(len);
    access(is_if, we, a, len, wd, d, lat);
    if (is_if) el = 6;
    else if (we) el = n + 1;
    else el = n + 2;
    check("latency", 64'(lat), 64'(el));
    e = ref_read(int'(a), n);
    if (is_if) begin
      check("if_data", 64'(d), 64'(e));
      if (have_mem) check("mem_hold", 64'(bus.mem_rdata), 64'(last_mem));
      last_if = e;
    end else begin
      check("if_hold", 64'(bus.if_data), 64'(last_if));
      if (we) begin
        for (int k = 0; k < n; k++)
          ref_mem[(int'(a) + k) & (MSZ - 1)] = wd[8*k +: 8];
        have_mem = 1'b0;
      end else begin
        check("mem_rdata", 64'(d), 64'(e));
        last_mem = e;
        have_mem = 1'b1;
      end
    end
    last_mem_ref = !is_if;
  endtask

  task automatic contend(input logic [AW-1:0] ia,
                         input logic [AW-1:0] ma,
                         input logic [1:0] ml);
    int got [2];
    int cnt;
    bit ov;
    bit mem_first;
    cnt = 0;
    ov = 1'b0;
    got[0] = -1;
    got[1] = -1;
    mem_first = !last_mem_ref;
    bus.if_req = 1'b1;
    bus.if_addr = ia;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_addr = ma;
    bus.mem_len = ml;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.if_done && bus.mem_done) ov = 1'b1;
      if (bus.if_done) begin
        if (cnt < 2) got[cnt] = 0;
        cnt++;
        last_if = ref_read(int'(ia), 4);
        check("ct_if_data", 64'(bus.if_data), 64'(last_if));
        bus.if_req = 1'b0;
      end
      if (bus.mem_done) begin
        if (cnt < 2) got[cnt] = 1;
        cnt++;
        last_mem = ref_read(int'(ma), nbytes(ml));
        check("ct_mem_data", 64'(bus.mem_rdata), 64'(last_mem));
        bus.mem_req = 1'b0;
      end
      if (cnt >= 2) break;
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    check("ct_count", 64'(cnt), 64'd2);
    check("ct_first", 64'(got[0]), 64'(mem_first));
    check("ct_second", 64'(got[1]), 64'(!mem_first));
    check("ct_overlap", 64'(ov), 64'd0);
    last_mem_ref = !mem_first;
    have_mem = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [31:0] wd;
    int mism;
    bit bad;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_len = 2'b00;
    bus.mem_wdata = 32'h0;
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    ram[32'h100] = 8'h11; ref_mem[32'h100] = 8'h11;
    ram[32'h101] = 8'h22; ref_mem[32'h101] = 8'h22;
    ram[32'h102] = 8'h33; ref_mem[32'h102] = 8'h33;
    ram[32'h103] = 8'h44; ref_mem[32'h103] = 8'h44;
    ram[32'h2000] = 8'hF0; ref_mem[32'h2000] = 8'hF0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_if_done", 64'(bus.if_done), 64'd0);
    check("rst_mem_done", 64'(bus.mem_done), 64'd0);
    check("rst_if_data", 64'(bus.if_data), 64'd0);
    check("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
    check("rst_ram_a", 64'(bus.ram_a), 64'd0);
    check("rst_ram_dout", 64'(bus.ram_dout), 64'd0);
    check("rst_ram_wr", 64'(bus.ram_wr), 64'd0);
    rst = 1'b0;
    last_mem_ref = 1'b0;
    last_if = 32'h0;
    last_mem = 32'h0;
    have_mem = 1'b1;

    contend(AW'(32'h100), AW'(32'h2000), 2'b00);
    contend(AW'(32'h100), AW'(32'h101), 2'b01);

    do_op(1'b1, 1'b0, AW'(32'h100), 2'b00, 32'h0);
    check("fetch_word", 64'(bus.if_data), 64'h44332211);
    do_op(1'b0, 1'b0, AW'(32'h2000), 2'b00, 32'h0);
    check("byte_load", 64'(bus.mem_rdata), 64'h000000F0);
    do_op(1'b0, 1'b1, AW'(32'h1FFFF), 2'b01, 32'hAABBCCDD);
    check("wrap_top", 64'(ram[32'h1FFFF]), 64'hDD);
    check("wrap_zero", 64'(ram[0]), 64'hCC);
    do_op(1'b1, 1'b0, AW'(32'h1FFFE), 2'b00, 32'h0);

    for (int i = 0; i < 80; i++) begin
      int sel;
      int r;
      logic [AW-1:0] a;
      sel = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r < 3) a = AW'(MSZ - 1 - int'($urandom_range(0, 3)));
      else if (r < 7) a = AW'($urandom_range(0, 63));
      else a = AW'($urandom);
      do_op(sel == 0, sel == 2, a, 2'($urandom), $urandom);
    end

    // word store interrupted by reset after two bytes
    wd = $urandom;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b1;
    bus.mem_addr = AW'(32'h40);
    bus.mem_len = 2'b10;
    bus.mem_wdata = wd;
    bad = 1'b0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_done) bad = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_req = 1'b0;
    #1;
    check("abort_wr", 64'(bus.ram_wr), 64'd0);
    check("abort_dout", 64'(bus.ram_dout), 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_done) bad = 1'b1;
    end
    check("abort_no_done", 64'(bad), 64'd0);
    ref_mem[32'h40] = wd[7:0];
    ref_mem[32'h41] = wd[15:8];
    check("abort_b0", 64'(ram[32'h40]), 64'(wd[7:0]));
    check("abort_b1", 64'(ram[32'h41]), 64'(wd[15:8]));
    check("abort_b2", 64'(ram[32'h42]), 64'(ref_mem[32'h42]));
    check("abort_b3", 64'(ram[32'h43]), 64'(ref_mem[32'h43]));
    rst = 1'b0;
    last_mem_ref = 1'b0;
    last_if = 32'h0;
    last_mem = 32'h0;
    have_mem = 1'b1;
    do_op(1'b1, 1'b0, AW'(32'h40), 2'b00, 32'h0);
    do_op(1'b0, 1'b1, AW'(32'h42), 2'b01, $urandom);
    do_op(1'b0, 1'b0, AW'(32'h40), 2'b10, 32'h0);

    mism = 0;
    for (int i = 0; i < MSZ; i++)
      if (ram[i] !== ref_mem[i]) mism++;
    check("ram_image", 64'(mism), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
